// File: rtl/multi_sync_if.sv
// multi_sync_if: asynchronous inputs and synchronised level/edge outputs of multi_sync
interface multi_sync_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] i_async_sig, o_q, o_rise, o_fall;
  modport master (output i_async_sig, input o_q, o_rise, o_fall);
  modport slave (input i_async_sig, output o_q, o_rise, o_fall);
endinterface

// File: rtl/multi_sync.sv
// multi_sync: per-channel CDC synchroniser, glitch filter under MULTI_SYNC_FILTER_EN, registered rise/fall pulses
module multi_sync #(
  parameter int WIDTH = 4,
  parameter int STAGES = 2,
  parameter int FILTER_LEN = 3
) (
  input logic clk,
  input logic rst,
  multi_sync_if.slave bus
);
  if (STAGES < 2) begin : g_bad_stages
    $error("multi_sync: STAGES must be at least 2");
  end
  if (FILTER_LEN < 1) begin : g_bad_filter
    $error("multi_sync: FILTER_LEN must be at least 1");
  end
  logic [WIDTH-1:0] r_sync [STAGES];
  logic [WIDTH-1:0] r_q, r_rise, r_fall, w_s, w_q_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= bus.i_async_sig;
      for (int k = 1; k < STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end
  assign w_s = r_sync[STAGES-1];
`ifdef MULTI_SYNC_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] TOP = CW'(FILTER_LEN - 1);
  logic [CW-1:0] r_cnt [WIDTH];
  always_comb begin
    w_q_nxt = r_q;
    for (int i = 0; i < WIDTH; i++)
      w_q_nxt[i] = (w_s[i] != r_q[i] && r_cnt[i] == TOP) ? w_s[i] : r_q[i];
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++)
      r_cnt[i] <= (rst || w_s[i] == r_q[i] || r_cnt[i] == TOP) ? '0 : r_cnt[i] + 1'b1;
  end
`else
  assign w_q_nxt = w_s;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_q <= w_q_nxt;
      r_rise <= w_q_nxt & ~r_q;
      r_fall <= ~w_q_nxt & r_q;
    end
  end
  assign bus.o_q = r_q;
  assign bus.o_rise = r_rise;
  assign bus.o_fall = r_fall;
endmodule

// File: tb/tb_multi_sync.sv
// tb_multi_sync: directed self-checking bench for multi_sync (filtered or unfiltered build)
module tb_multi_sync;
`ifdef MULTI_SYNC_FILTER_EN
  localparam int LAT = 5;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit FILT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  multi_sync_if #(.WIDTH(4)) bus ();
  multi_sync #(.WIDTH(4), .STAGES(2), .FILTER_LEN(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, int n, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask
  task automatic chk3(string tag, int n, logic [3:0] eq, logic [3:0] er, logic [3:0] ef);
    chk({tag, ".q"}, n, bus.o_q, eq);
    chk({tag, ".rise"}, n, bus.o_rise, er);
    chk({tag, ".fall"}, n, bus.o_fall, ef);
    chk({tag, ".excl"}, n, bus.o_rise & bus.o_fall, 4'b0000);
  endtask
  initial begin
    rst = 1'b1;
    bus.i_async_sig = 4'h0;
    #2 bus.i_async_sig = 4'hF;
    for (int n = 1; n <= 2; n++) begin
      tick;
      chk3("reset", n, 4'h0, 4'h0, 4'h0);
    end
    rst = 1'b0;
    for (int n = 1; n <= LAT + 1; n++) begin
      tick;
      chk3("powerup", n, n >= LAT ? 4'hF : 4'h0, n == LAT ? 4'hF : 4'h0, 4'h0);
    end
    #1 bus.i_async_sig = 4'h0;
    for (int n = 1; n <= LAT + 1; n++) begin
      tick;
      chk3("clear", n, n >= LAT ? 4'h0 : 4'hF, 4'h0, n == LAT ? 4'hF : 4'h0);
    end
    #1 bus.i_async_sig = 4'b0001;
    for (int n = 1; n <= LAT + 1; n++) begin
      tick;
      chk3("rise0", n, n >= LAT ? 4'b0001 : 4'b0000, n == LAT ? 4'b0001 : 4'b0000, 4'h0);
    end
    #1 bus.i_async_sig = 4'b0011;
    for (int n = 1; n <= 7; n++) begin
      tick;
      if (FILT)
        chk3("glitch", n, 4'b0001, 4'h0, 4'h0);
      else
        chk3("glitch", n, (n == 3 || n == 4) ? 4'b0011 : 4'b0001,
             n == 3 ? 4'b0010 : 4'b0000, n == 5 ? 4'b0010 : 4'b0000);
      if (n == 2) #1 bus.i_async_sig = 4'b0001;
    end
    #1 bus.i_async_sig = 4'b0100;
    for (int n = 1; n <= LAT + 1; n++) begin
      tick;
      chk3("to_ch2", n, n >= LAT ? 4'b0100 : 4'b0001, n == LAT ? 4'b0100 : 4'b0000,
           n == LAT ? 4'b0001 : 4'b0000);
    end
    #1 bus.i_async_sig = 4'b0001;
    for (int n = 1; n <= LAT + 1; n++) begin
      tick;
      chk3("swap", n, n >= LAT ? 4'b0001 : 4'b0100, n == LAT ? 4'b0001 : 4'b0000,
           n == LAT ? 4'b0100 : 4'b0000);
    end
    #1 bus.i_async_sig = 4'b1001;
    for (int n = 1; n <= LAT - 2; n++) begin
      tick;
      chk3("pre_rst", n, 4'b0001, 4'h0, 4'h0);
    end
    #1 rst = 1'b1;
    tick;
    chk3("mid_rst", 0, 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    for (int n = 1; n <= LAT + 1; n++) begin
      tick;
      chk3("post_rst", n, n >= LAT ? 4'b1001 : 4'b0000, n == LAT ? 4'b1001 : 4'b0000, 4'h0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multi_sync.md
MULTI_SYNC -- requirements
Module: multi_sync

Interface
REQ-001 Parameter WIDTH, default 4: number of independent asynchronous input channels.
REQ-002 Parameter STAGES, default 2: synchroniser flop depth per channel; values below 2 SHALL cause an elaboration error.
REQ-003 Parameter FILTER_LEN, default 3: consecutive stable cycles required before q changes; values below 1 SHALL cause an elaboration error.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 async_sig  input  WIDTH  asynchronous inputs, one bit per channel, no timing relation to clk.
REQ-007 q  output  WIDTH  synchronised, filtered level per channel, registered.
REQ-008 rise  output  WIDTH  one-cycle pulse per channel on q 0->1, registered.
REQ-009 fall  output  WIDTH  one-cycle pulse per channel on q 1->0, registered.

Function
REQ-010 Each channel SHALL pass async_sig through a STAGES-deep flop chain; last stage output is s.
REQ-011 Only the first chain flop SHALL sample async_sig; no logic between chain flops.
REQ-012 Each channel SHALL hold a counter of width clog2(FILTER_LEN+1), saturating never above FILTER_LEN-1.
REQ-013 s equal to q: counter SHALL clear to 0 that cycle.
REQ-014 s differing from q with counter below FILTER_LEN-1: counter SHALL increment by 1.
REQ-015 s differing from q with counter at FILTER_LEN-1: q SHALL take s and counter SHALL clear, same edge.
REQ-016 An s excursion shorter than FILTER_LEN cycles SHALL leave q unchanged and the counter at 0 once s returns.
REQ-017 Latency, single clean input change: q SHALL show the new value STAGES+FILTER_LEN edges after the edge that first samples it.
REQ-018 rise[i] SHALL be 1 exactly in the first cycle q[i] shows 1 after being 0; fall[i] likewise for 1->0; both 0 otherwise.
REQ-019 rise[i] and fall[i] SHALL never be 1 in the same cycle.
REQ-020 Channels SHALL be fully independent; simultaneous changes on several channels SHALL produce pulses on all of them in their respective cycles.
REQ-021 FILTER_LEN=1 SHALL make q a one-cycle registered copy of s.

Reset
REQ-022 rst high at an edge SHALL clear all chain flops, counters, q, rise and fall to 0 at that edge.
REQ-023 rst mid-count SHALL discard the count; no rise/fall pulse SHALL be produced by reset itself.
REQ-024 After rst deasserts with async_sig[i] held 1, rise[i] SHALL pulse once, STAGES+FILTER_LEN edges after the first non-reset edge.

Configuration
REQ-025 Macro MULTI_SYNC_FILTER_EN defined: filter counters present, behaviour per REQ-012..REQ-017.
REQ-026 Macro MULTI_SYNC_FILTER_EN undefined: no counters; q SHALL be s registered one cycle (latency STAGES+1); FILTER_LEN ignored; rise/fall per REQ-018.

Verification
REQ-027 All scenarios with WIDTH=4, STAGES=2, FILTER_LEN=3, clk period 10 ns; input edges at non-multiples of 5 ns (e.g. 7, 13, 19 ns offsets).
REQ-028 rst high 2 cycles with async_sig=4'hF -> q, rise, fall all 0 during reset; after release q=4'hF after 5 edges, rise=4'hF for exactly one cycle.
REQ-029 async_sig[0] 0->1 and held -> q[0]=1 on 5th edge after first sampling edge; rise[0] one cycle; q[3:1], rise[3:1], fall all 0.
REQ-030 2-cycle high glitch on async_sig[1] -> filter on: q[1], rise[1], fall[1] stay 0; filter off: q[1] high 2 cycles, rise[1] then fall[1] one cycle each.
REQ-031 Same cycle, async_sig[0] 0->1 and async_sig[2] 1->0 (from settled q=4'b0100) -> one cycle with rise=4'b0001 and fall=4'b0100.
REQ-032 async_sig[3] raised, rst asserted after 2 stable s cycles for 1 cycle -> q[3]=0, no pulse; q[3] rises 5 edges after the first post-reset edge.
